// File: rtl/mm_booth_r4_seq_mult_pkg.sv
// Shared widths and types for the iterative radix-4 Booth multiplier.
package bit_width;
  localparam int INWIDTH  = 16;
  localparam int OUTWIDTH = 2 * INWIDTH;
endpackage

package mm_defs;
  typedef enum {MULT_SIMULATION, MULT_BOOTH_RADIX4, MULT_WALLACE} mult_method_e;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mm_mult_state_e;

  typedef enum logic [2:0] {B_ZERO, B_POS1, B_POS2, B_NEG1, B_NEG2} booth_digit_e;

  function automatic int booth_digits(int width);
    return (width + 2) / 2;
  endfunction
endpackage

// File: rtl/mm_booth_r4_seq_mult_encode.sv
// Radix-4 Booth recoder: bit triplet -> signed digit and partial product of the extended multiplicand.
module mm_booth_r4_encode
  import mm_defs::*;
#(
  parameter int EW = 18
) (
  input  logic [2:0]    triplet_i,
  input  logic [EW-1:0] mcand_i,
  output booth_digit_e  digit_o,
  output logic [EW+1:0] pp_o
);

  logic [EW+1:0] m1;
  logic [EW+1:0] m2;

  assign m1 = {{2{mcand_i[EW-1]}}, mcand_i};
  assign m2 = m1 << 1;

  always_comb begin
    digit_o = B_ZERO;
    pp_o    = '0;
    case (triplet_i)
      3'b001, 3'b010: begin digit_o = B_POS1; pp_o = m1;  end
      3'b011:         begin digit_o = B_POS2; pp_o = m2;  end
      3'b100:         begin digit_o = B_NEG2; pp_o = -m2; end
      3'b101, 3'b110: begin digit_o = B_NEG1; pp_o = -m1; end
      default:        ;
    endcase
  end

endmodule

// File: rtl/mm_booth_r4_seq_mult.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes; one Booth digit per CALC cycle.
module mm_booth_r4_seq_mult
  import mm_defs::*;
#(
  parameter int           INWIDTH  = bit_width::INWIDTH,
  parameter mult_method_e METHOD   = MULT_BOOTH_RADIX4,
  localparam int          OUTWIDTH = 2 * INWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INWIDTH-1:0]  in_a,
  input  logic [INWIDTH-1:0]  in_b,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUTWIDTH-1:0] out_product,
  output logic                busy
);

  localparam int EW = INWIDTH + 2;
  localparam int AW = INWIDTH + 4;
  localparam int TW = AW + EW;
  localparam int N  = booth_digits(INWIDTH);
  localparam int CW = $clog2(N + 1);

  if ((INWIDTH % 2) != 0 || INWIDTH < 4) begin : g_param_check
    $error("mm_booth_r4_seq_mult: INWIDTH must be even and >= 4");
  end

  mm_mult_state_e      state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       acc_q, acc_d;
  logic [EW-1:0]       mcand_q, mcand_d;
  logic                prev_q, prev_d;
  logic [OUTWIDTH-1:0] prod_q, prod_d;

  logic                accept;
  logic [EW-1:0]       a_ext, b_ext;
  logic [OUTWIDTH-1:0] sim_prod;
  booth_digit_e        digit;
  logic [AW-1:0]       pp;
  logic [AW-1:0]       hi_sum;
  logic [TW-1:0]       shifted;

  assign in_ready    = !clear && (state_q == IDLE || (state_q == DONE && out_ready));
  assign accept      = in_valid && in_ready;
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign out_product = prod_q;

  assign a_ext    = {{2{in_signed & in_a[INWIDTH-1]}}, in_a};
  assign b_ext    = {{2{in_signed & in_b[INWIDTH-1]}}, in_b};
  assign sim_prod = OUTWIDTH'($signed(a_ext)) * OUTWIDTH'($signed(b_ext));

  // Low EW bits of the accumulator hold the not-yet-consumed multiplier bits.
  mm_booth_r4_encode #(.EW(EW)) u_enc (
    .triplet_i ({acc_q[1:0], prev_q}),
    .mcand_i   (mcand_q),
    .digit_o   (digit),
    .pp_o      (pp)
  );

  assign hi_sum  = acc_q[TW-1 -: AW] + ((digit == B_ZERO) ? '0 : pp);
  assign shifted = $signed({hi_sum, acc_q[EW-1:0]}) >>> 2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      prev_q  <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      prev_q  <= prev_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    prev_d  = prev_q;
    prod_d  = prod_q;

    case (state_q)
      CALC: begin
        acc_d  = shifted;
        prev_d = acc_q[1];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          prod_d  = shifted[OUTWIDTH-1:0];
        end
      end
      DONE:    if (out_ready) state_d = IDLE;
      default: ;
    endcase

    // Any method other than the behavioural model runs on the Booth engine.
    if (accept) begin
      if (METHOD == MULT_SIMULATION) begin
        state_d = DONE;
        prod_d  = sim_prod;
      end else begin
        state_d = CALC;
        cnt_d   = CW'(N);
        acc_d   = {{AW{1'b0}}, b_ext};
        mcand_d = a_ext;
        prev_d  = 1'b0;
      end
    end

    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

endmodule

// File: tb/tb_mm_booth_r4_seq_mult.sv
// Scoreboard bench: Booth and behavioural instances driven with directed and random operands.
module tb_mm_booth_r4_seq_mult;

  localparam int NRAND = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rand_on;
  logic        clear     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [15:0] in_a      [2];
  logic [15:0] in_b      [2];
  logic        in_signed [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_product [2];
  logic        busy      [2];

  int total = 0;
  int bad   = 0;
  logic [31:0] expq0[$];
  logic [31:0] expq1[$];

  initial forever #5 clk = ~clk;

  mm_booth_r4_seq_mult #(.INWIDTH(16), .METHOD(mm_defs::MULT_BOOTH_RADIX4)) u_booth (
    .clk(clk), .rst_n(rst_n), .clear(clear[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .in_signed(in_signed[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_product(out_product[0]), .busy(busy[0])
  );

  mm_booth_r4_seq_mult #(.INWIDTH(16), .METHOD(mm_defs::MULT_SIMULATION)) u_sim (
    .clk(clk), .rst_n(rst_n), .clear(clear[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .in_signed(in_signed[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_product(out_product[1]), .busy(busy[1])
  );

  function automatic logic [31:0] ref_mult(logic [15:0] a, logic [15:0] b, logic s);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    return 32'(pa * pb);
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 9))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h0000;
      3:       return 16'h7FFF;
      4:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drives one operand pair; returns one step after the accepting edge.
  task automatic issue(int idx, logic [15:0] a, logic [15:0] b, logic s);
    logic ok;
    ok = 1'b0;
    in_a[idx] = a; in_b[idx] = b; in_signed[idx] = s; in_valid[idx] = 1'b1;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (in_ready[idx]) begin
        ok = 1'b1;
        if (idx == 0) expq0.push_back(ref_mult(a, b, s));
        else          expq1.push_back(ref_mult(a, b, s));
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: in_ready never rose", idx);
    end
    @(posedge clk); #1;
    in_valid[idx] = 1'b0;
    in_a[idx] = 16'($urandom); in_b[idx] = 16'($urandom); in_signed[idx] = 1'($urandom);
  endtask

  task automatic wait_idle(int idx);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (!busy[idx]) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL idle_timeout%0d: busy stuck", idx);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_stream(int idx);
    for (int n = 0; n < NRAND; n++) begin
      issue(idx, pick(), pick(), 1'($urandom));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
  endtask

  // Monitor: every product handed over must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid[0] && out_ready[0]) begin
      if (expq0.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_out0: got %h expected nothing", out_product[0]);
      end else check("product_booth", out_product[0], expq0.pop_front());
    end
    if (rst_n && out_valid[1] && out_ready[1]) begin
      if (expq1.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_out1: got %h expected nothing", out_product[1]);
      end else check("product_sim", out_product[1], expq1.pop_front());
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_on) begin
      out_ready[0] = ($urandom_range(0, 3) != 0);
      out_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [31:0] hold_p;
    logic        flag;
    longint      t0;

    rst_n = 1'b0; rand_on = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clear[i] = 1'b0; in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
      in_signed[i] = 1'b0; out_ready[i] = 1'b1;
    end

    #12;
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_product", out_product[0], 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready_booth", 32'(in_ready[0]), 32'd1);
    check("rst_in_ready_sim", 32'(in_ready[1]), 32'd1);

    // Latency: out_valid on the 10th edge counting the accept edge.
    issue(0, 16'hFFFF, 16'hFFFF, 1'b0);
    repeat (8) @(posedge clk);
    #1 check("lat_before", 32'(out_valid[0]), 32'd0);
    @(posedge clk); #1;
    check("lat_at", 32'(out_valid[0]), 32'd1);
    wait_idle(0);

    issue(0, 16'h8000, 16'h8000, 1'b1); wait_idle(0);
    issue(0, 16'hFFFD, 16'h0007, 1'b1); wait_idle(0);

    // Back-pressure, then back-to-back accept on the releasing edge.
    out_ready[0] = 1'b0;
    issue(0, 16'h1234, 16'hABCD, 1'b1);
    flag = 1'b0;
    for (int k = 0; k < 50 && !flag; k++) begin @(negedge clk); flag = out_valid[0]; end
    check("bp_valid_rose", 32'(flag), 32'd1);
    hold_p = out_product[0];
    check("bp_value", hold_p, ref_mult(16'h1234, 16'hABCD, 1'b1));
    flag = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(out_valid[0] && out_product[0] == hold_p && !in_ready[0])) flag = 1'b0;
    end
    check("bp_hold", 32'(flag), 32'd1);
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    t0 = longint'($time);
    issue(0, 16'h0102, 16'h0304, 1'b0);
    check("b2b_edges", 32'(longint'($time) - t0), 32'd10);
    check("b2b_busy", {30'd0, busy[0], out_valid[0]}, 32'd2);
    wait_idle(0);

    // Abort mid-CALC.
    issue(0, 16'h1111, 16'h2222, 1'b0);
    repeat (3) @(posedge clk);
    #1 clear[0] = 1'b1;
    @(negedge clk);
    check("clr_in_ready", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    clear[0] = 1'b0;
    check("clr_idle", {30'd0, busy[0], out_valid[0]}, 32'd0);
    void'(expq0.pop_back());
    flag = 1'b0;
    repeat (15) begin @(negedge clk); flag |= out_valid[0]; end
    check("clr_no_valid", 32'(flag), 32'd0);
    @(posedge clk); #1;
    clear[0] = 1'b1; in_valid[0] = 1'b1; in_a[0] = 16'd9; in_b[0] = 16'd9;
    @(negedge clk);
    check("clr_blocks_accept", 32'(in_ready[0]), 32'd0);
    @(posedge clk); #1;
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    check("clr_dropped", 32'(busy[0]), 32'd0);
    issue(0, 16'd5, 16'd6, 1'b0); wait_idle(0);

    // Asynchronous reset mid-CALC.
    issue(0, 16'd7, 16'd9, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_outputs", {out_product[0][29:0], busy[0], out_valid[0]}, 32'd0);
    void'(expq0.pop_back());
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;

    rand_on = 1'b1;
    fork
      rand_stream(0);
      rand_stream(1);
    join
    rand_on = 1'b0;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 200 && !flag; k++) begin
      @(negedge clk);
      flag = (expq0.size() == 0 && expq1.size() == 0);
    end
    check("drain_booth", 32'(expq0.size()), 32'd0);
    check("drain_sim", 32'(expq1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
